plantard_const_mul_stream: RTL and testbench

//  Streaming fixed-constant modular multiplier, mod q = 12289. Computes out = (a * C_MUL) mod q.

---
 rtl/plantard_const_mul_stream_if.sv | 24 ++
 rtl/plantard_const_mul_stream.sv | 132 +++++++++++++
 tb/tb_plantard_const_mul_stream.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/plantard_const_mul_stream_if.sv
// Valid/ready stream bundle for the Plantard constant multiplier: coefficient in, product out, frame status.
interface plantard_const_mul_stream_if #(
  parameter int DATA_WIDTH = 14
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [7:0]            frame_cnt;
  logic                  err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_cnt, err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_cnt, err
  );
endinterface

// File: rtl/plantard_const_mul_stream.sv
// Streaming (a * C_MUL) mod Q via Plantard reduction; 4-cycle latency, whole pipe holds while out_valid & ~out_ready.
// Optional PLANTARD_RANGE_CHECK_EN: sticky err on an accepted in_data >= Q, whose result is forced to 0.
module plantard_const_mul_stream #(
  parameter int                    DATA_WIDTH = 14,
  parameter logic [DATA_WIDTH-1:0] Q          = 14'd12289,
  parameter logic [DATA_WIDTH-1:0] C_MUL      = 14'd10810,
  parameter int                    N_COEF     = 512
) (
  input logic                       clk,
  input logic                       rst,
  plantard_const_mul_stream_if.slave bus
);

  localparam int L  = 15;
  localparam int PW = DATA_WIDTH + L;
  localparam int SW = PW + 1;
  localparam int CW = $clog2(N_COEF);

  // Plantard constant: (-C_MUL * 2^30 mod Q) * Q^-1 mod 2^30, so the reduction's 2^-30 factor cancels out.
  function automatic logic [2*L-1:0] plantard_pc(input logic [63:0] c, input logic [63:0] q);
    logic [63:0] inv;
    logic [63:0] r30;
    logic [63:0] b;
    inv = q;
    for (int i = 0; i < 5; i++) begin
      inv = inv * (64'd2 - q * inv);
    end
    r30 = (64'd1 << (2 * L)) % q;
    b   = (c * ((q - r30) % q)) % q;
    return (2*L)'((b * inv) & ((64'd1 << (2 * L)) - 64'd1));
  endfunction

  localparam logic [2*L-1:0] PC     = plantard_pc(64'(C_MUL), 64'(Q));
  localparam logic [L-1:0]   PC_LOW = PC[L-1:0];
  localparam logic [L-1:0]   PC_UP  = PC[2*L-1:L];

  logic                  v1, v2, v3, v4;
  logic [L-1:0]          p_up_lo;
  logic [DATA_WIDTH-1:0] p_low_hi;
  logic [L-1:0]          t;
  logic [PW-1:0]         tq;
  logic [DATA_WIDTH-1:0] res;
  logic [L-1:0]          r;
  logic [CW-1:0]         cnt;
  logic [7:0]            frame_cnt;
  logic                  adv;
  logic                  acc;
  logic                  xfer;

  assign adv  = ~v4 | bus.out_ready;
  assign acc  = bus.in_valid & adv & ~rst;
  assign xfer = v4 & bus.out_ready;

  // Final stage: (t*Q + Q) >> 15 needs one bit more than the product.
  always_comb begin
    r = L'((SW'(tq) + SW'(Q)) >> L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      v4        <= 1'b0;
      p_up_lo   <= '0;
      p_low_hi  <= '0;
      t         <= '0;
      tq        <= '0;
      res       <= '0;
      cnt       <= '0;
      frame_cnt <= '0;
    end else begin
      if (xfer) begin
        if (cnt == CW'(N_COEF - 1)) begin
          cnt       <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (adv) begin
        // Only bits [29:15] of (up<<15)+low matter: keep up[14:0] and low[28:15]; the low half never carries.
        v1       <= acc;
        p_up_lo  <= L'(PW'(bus.in_data) * PW'(PC_UP));
        p_low_hi <= DATA_WIDTH'((PW'(bus.in_data) * PW'(PC_LOW)) >> L);
        v2       <= v1;
        t        <= p_up_lo + L'(p_low_hi);
        v3       <= v2;
        tq       <= PW'(t) * PW'(Q);
        v4       <= v3;
        res      <= (r == L'(Q)) ? '0 : DATA_WIDTH'(r);
      end
    end
  end

`ifdef PLANTARD_RANGE_CHECK_EN
  logic b1, b2, b3, b4;
  logic err;

  always_ff @(posedge clk) begin
    if (rst) begin
      b1  <= 1'b0;
      b2  <= 1'b0;
      b3  <= 1'b0;
      b4  <= 1'b0;
      err <= 1'b0;
    end else begin
      if (acc && (bus.in_data >= Q)) begin
        err <= 1'b1;
      end
      if (adv) begin
        b1 <= acc & (bus.in_data >= Q);
        b2 <= b1;
        b3 <= b2;
        b4 <= b3;
      end
    end
  end

  assign bus.out_data = b4 ? '0 : res;
  assign bus.err      = err;
`else
  assign bus.out_data = res;
  assign bus.err      = 1'b0;
`endif

  assign bus.in_ready  = adv & ~rst;
  assign bus.out_valid = v4;
  assign bus.out_last  = v4 & (cnt == CW'(N_COEF - 1));
  assign bus.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_plantard_const_mul_stream.sv
// Scoreboard bench: accepted coefficients queue their (a*C) mod Q result; a negedge monitor pops and checks outputs.
module tb_plantard_const_mul_stream;
  localparam int Q = 12289;
  localparam int C = 10810;
  localparam int N = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  plantard_const_mul_stream_if #(.DATA_WIDTH(14)) bus();

  plantard_const_mul_stream dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          exp_q[$];
  int          xfers = 0;
  int          or_mode = 0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [13:0] prev_d = '0;

  function automatic int model(input int a);
`ifdef PLANTARD_RANGE_CHECK_EN
    if (a >= Q) return 0;
`endif
    return (a * C) % Q;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // out_ready policy: 0 hold low, 1 hold high, 2 random 50%
  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard push on accept, pop/compare on transfer, hold check while stalled
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      xfers  = 0;
      prev_v = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(int'(bus.in_data)));
      if (prev_v && !prev_r) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_data", int'(bus.out_data), int'(prev_d));
      end
      if (bus.out_valid) begin
        check("out_last", int'(bus.out_last), int'((xfers % N) == N - 1));
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_data: got %0d with no pending expectation", bus.out_data);
          end else begin
            check("out_data", int'(bus.out_data), exp_q.pop_front());
          end
          check("frame_cnt_xfer", int'(bus.frame_cnt), (xfers / N) % 256);
          xfers++;
        end
      end
      prev_v = bus.out_valid;
      prev_r = bus.out_ready;
      prev_d = bus.out_data;
    end
  end

  task automatic send(input int a);
    bus.in_valid = 1'b1;
    bus.in_data  = 14'(a);
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    or_mode      = 0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_frame_cnt", int'(bus.frame_cnt), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_err", int'(bus.err), 0);
  endtask

  task automatic set_mode(input int m);
    or_mode = m;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int vec[4];
    int a;
    vec[0] = 0;
    vec[1] = 1;
    vec[2] = 2;
    vec[3] = 12288;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset and directed vectors with exact latency
    do_reset();
    set_mode(1);
    fork
      begin
        @(negedge clk);
        check("lat_accept", int'(bus.in_valid && bus.in_ready), 1);
        for (int k = 1; k <= 4; k++) begin
          @(negedge clk);
          check($sformatf("lat_valid_c%0d", k), int'(bus.out_valid), int'(k == 4));
        end
      end
      begin
        for (int i = 0; i < 4; i++) send(vec[i]);
      end
    join
    drain();

    // One full frame of a = 0..511 back to back
    do_reset();
    set_mode(1);
    for (int i = 0; i < N; i++) send(i);
    drain();
    check("frame1_cnt", int'(bus.frame_cnt), 1);

    // Downstream stall for 10 cycles in mid-stream
    fork
      begin
        for (int i = 0; i < N; i++) send($urandom_range(0, Q - 1));
      end
      begin
        repeat (100) @(negedge clk);
        or_mode = 0;
        repeat (10) @(negedge clk);
        check("stall_in_ready", int'(bus.in_ready), 0);
        check("stall_out_valid", int'(bus.out_valid), 1);
        or_mode = 1;
      end
    join
    drain();
    check("frame2_cnt", int'(bus.frame_cnt), 2);

    // Random in_valid / out_ready for three frames
    do_reset();
    set_mode(2);
    for (int i = 0; i < 3 * N; i++) begin
      send($urandom_range(0, Q - 1));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    check("frame3_cnt", int'(bus.frame_cnt), 3);

    // Reset with three items in flight, then a fresh frame from index 0
    set_mode(1);
    for (int i = 0; i < 3; i++) send($urandom_range(0, Q - 1));
    do_reset();
    set_mode(1);
    for (int i = 0; i < N; i++) send($urandom_range(0, Q - 1));
    drain();
    check("restart_frame_cnt", int'(bus.frame_cnt), 1);

    // Range check
`ifdef PLANTARD_RANGE_CHECK_EN
    send(Q);
    drain();
    check("err_set", int'(bus.err), 1);
    a = $urandom_range(1, Q - 1);
    send(a);
    drain();
    check("err_sticky", int'(bus.err), 1);
`else
    a = $urandom_range(1, Q - 1);
    send(a);
    drain();
    check("err_tied_low", int'(bus.err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
